rs_issue_queue: RTL and testbench

Parametrised reservation station between the Decoder and the ALU. It holds up to 2^DEPTH_BIT dispatched ops and captures operands from NUM_CDB result broadcast channels, including same-cycle bypass at dispatch. Each cycle it selects the oldest op whose operands are all ready and sends it to the ALU through a registered valid/ready issue port. It replaces the single-CDB, lowest-index-first station, which had no issue back-pressure.

---
 rtl/rs_issue_queue_pkg.sv | 26 ++
 rtl/rs_age_matrix.sv | 60 ++++++
 rtl/rs_issue_queue.sv | 249 ++++++++++++++++++++++++
 tb/tb_rs_issue_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// rs_issue_queue_pkg
//   Shared constants for the reservation station slice: default entry-count
//   exponent, ROB tag width, CDB channel count, op field width and data width,
//   plus the op-type codes carried in the op field.
// ---------------------------------------------------------------------------
package rs_issue_queue_pkg;

    localparam int RS_WIDTH_BIT = 3;   // log2 of reservation station entries
    localparam int ROB_TAG_W    = 5;   // ROB tag width
    localparam int CDB_CHANNELS = 2;   // result broadcast channels
    localparam int OP_FIELD_W   = 7;   // op/type field width
    localparam int DATA_W       = 32;  // datapath width

    // Op-type codes carried in the op field (RV32I major opcodes)
    typedef enum logic [OP_FIELD_W-1:0] {
        OPT_LUI    = 7'b0110111,
        OPT_AUIPC  = 7'b0010111,
        OPT_JAL    = 7'b1101111,
        OPT_JALR   = 7'b1100111,
        OPT_BRANCH = 7'b1100011,
        OPT_OP_IMM = 7'b0010011,
        OPT_OP     = 7'b0110011
    } op_type_e;

endpackage

// File: rtl/rs_age_matrix.sv
// ---------------------------------------------------------------------------
// rs_age_matrix
//   DEPTH x DEPTH age matrix. age_q[i][j] = 1 means entry j is older than
//   entry i. Picks the oldest eligible entry as a one-hot vector.
// Ports
//   clk_in, rst_in : clock, asynchronous active-high reset
//   clear          : synchronous flush of all age state
//   alloc          : one-hot slot being written this edge (0 when none)
//   free           : one-hot slot being released this edge (0 when none)
//   eligible       : entries that may be selected this cycle
//   oldest         : one-hot oldest eligible entry
//   any            : at least one entry is eligible
// ---------------------------------------------------------------------------
module rs_age_matrix
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH = 1 << RS_WIDTH_BIT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] oldest,
    output logic             any
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_q;

    // A new entry is younger than everything still resident after this edge.
    // Its column is cleared in every other row, so stale bits left by a
    // previous occupant of the slot never survive reallocation.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= '0;
            age_q <= '0;
        end else if (clear) begin
            vld_q <= '0;
            age_q <= '0;
        end else begin
            vld_q <= (vld_q & ~free) | alloc;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i]) age_q[i] <= vld_q & ~free;
                else          age_q[i] <= age_q[i] & ~alloc;
            end
        end
    end

    // Oldest = eligible with no eligible entry older than it. Ages form a
    // strict total order over resident entries, so at most one bit is set.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            oldest[i] = eligible[i] && !(|(age_q[i] & eligible));
    end

    assign any = |eligible;

endmodule

// File: rtl/rs_issue_queue.sv
// ---------------------------------------------------------------------------
// rs_issue_queue
//   Reservation station between decoder and ALU. Holds 2^DEPTH_BIT ops,
//   captures operands from NUM_CDB broadcast channels (also at dispatch) and
//   issues the oldest ready op through a registered valid/ready port.
// Ports
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   rdy_in                : global stall, all state holds while low
//   clear_flag            : synchronous flush
//   in_*                  : dispatch request (in_valid/in_ready handshake)
//   cdb_valid/rob_id/val  : packed broadcast channels, channel k at slice k
//   iss_*                 : issue register (iss_valid/iss_ready handshake)
//   count                 : occupied entries, excluding the issue register
// ---------------------------------------------------------------------------
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH_BIT = RS_WIDTH_BIT,
    parameter int ROB_BIT   = ROB_TAG_W,
    parameter int NUM_CDB   = CDB_CHANNELS,
    parameter int OP_W      = OP_FIELD_W,
    parameter int XLEN      = DATA_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear_flag,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [XLEN-1:0]            in_vj,
    input  logic [XLEN-1:0]            in_vk,
    input  logic                       in_qj_busy,
    input  logic                       in_qk_busy,
    input  logic [ROB_BIT-1:0]         in_qj,
    input  logic [ROB_BIT-1:0]         in_qk,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       in_itype,
    input  logic [ROB_BIT-1:0]         in_rob_id,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_BIT-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [XLEN-1:0]            iss_vj,
    output logic [XLEN-1:0]            iss_vk,
    output logic [XLEN-1:0]            iss_imm,
    output logic [XLEN-1:0]            iss_pc,
    output logic                       iss_itype,
    output logic [ROB_BIT-1:0]         iss_rob_id,
    output logic [DEPTH_BIT:0]         count
);

    localparam int DEPTH = 1 << DEPTH_BIT;

    // Fields that travel to the ALU
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    vj;
        logic [XLEN-1:0]    vk;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic               itype;
        logic [ROB_BIT-1:0] rob_id;
    } payload_t;

    typedef struct packed {
        logic               valid;
        logic               qj_busy;
        logic               qk_busy;
        logic [ROB_BIT-1:0] qj;
        logic [ROB_BIT-1:0] qk;
        payload_t           pl;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] ent_vld, ent_elig, free_vec, alloc_oh, oldest_oh, issue_oh;
    logic             any_elig, upd, disp_fire, iss_load, iss_take;
    entry_t           new_ent;
    payload_t         sel_pl;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i]  = ent_q[i].valid;
            // Registered state only: a wakeup this cycle issues next cycle
            ent_elig[i] = ent_q[i].valid && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++)
            count = count + (DEPTH_BIT+1)'(ent_vld[i]);
    end

    // Occupancy comes from registers only, so a slot freed by this cycle's
    // issue is not offered to dispatch until the next cycle.
    assign free_vec  = ~ent_vld;
    assign in_ready  = |free_vec;

    assign upd       = rdy_in && !clear_flag;
    assign disp_fire = upd && in_valid && in_ready;
    assign iss_load  = !iss_valid || iss_ready;
    assign iss_take  = upd && iss_load && any_elig;
    assign issue_oh  = oldest_oh & {DEPTH{iss_take}};

    // Lowest-index free slot
    for (genvar g = 0; g < DEPTH; g++) begin : g_alloc
        if (g == 0) begin : g_first
            assign alloc_oh[g] = free_vec[g];
        end else begin : g_rest
            assign alloc_oh[g] = free_vec[g] && !(|free_vec[g-1:0]);
        end
    end

    // Dispatch bypass: scan high to low so the lowest matching channel wins
    logic             byp_j, byp_k;
    logic [XLEN-1:0]  byp_vj, byp_vk;

    always_comb begin
        byp_j  = 1'b0;
        byp_k  = 1'b0;
        byp_vj = '0;
        byp_vk = '0;
        for (int k = NUM_CDB-1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == in_qj) begin
                byp_j  = 1'b1;
                byp_vj = cdb_val[k*XLEN +: XLEN];
            end
            if (cdb_valid[k] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == in_qk) begin
                byp_k  = 1'b1;
                byp_vk = cdb_val[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.qj_busy   = in_qj_busy && !byp_j;
        new_ent.qk_busy   = in_qk_busy && !byp_k;
        new_ent.qj        = in_qj;
        new_ent.qk        = in_qk;
        new_ent.pl.op     = in_op;
        new_ent.pl.vj     = (in_qj_busy && byp_j) ? byp_vj : in_vj;
        new_ent.pl.vk     = (in_qk_busy && byp_k) ? byp_vk : in_vk;
        new_ent.pl.imm    = in_imm;
        new_ent.pl.pc     = in_pc;
        new_ent.pl.itype  = in_itype;
        new_ent.pl.rob_id = in_rob_id;
    end

    // Per-entry wakeup and state
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic            hit_j, hit_k;
        logic [XLEN-1:0] cap_j, cap_k;

        always_comb begin
            hit_j = 1'b0;
            hit_k = 1'b0;
            cap_j = '0;
            cap_k = '0;
            for (int k = NUM_CDB-1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_q[g].qj) begin
                    hit_j = 1'b1;
                    cap_j = cdb_val[k*XLEN +: XLEN];
                end
                if (cdb_valid[k] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_q[g].qk) begin
                    hit_k = 1'b1;
                    cap_k = cdb_val[k*XLEN +: XLEN];
                end
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                ent_q[g] <= '0;
            end else if (rdy_in) begin
                if (clear_flag) begin
                    ent_q[g].valid <= 1'b0;
                end else if (disp_fire && alloc_oh[g]) begin
                    ent_q[g] <= new_ent;
                end else begin
                    if (issue_oh[g]) ent_q[g].valid <= 1'b0;
                    if (ent_q[g].valid && ent_q[g].qj_busy && hit_j) begin
                        ent_q[g].qj_busy <= 1'b0;
                        ent_q[g].pl.vj   <= cap_j;
                    end
                    if (ent_q[g].valid && ent_q[g].qk_busy && hit_k) begin
                        ent_q[g].qk_busy <= 1'b0;
                        ent_q[g].pl.vk   <= cap_k;
                    end
                end
            end
        end
    end

    // Stall gating is applied here so the matrix only ever sees real events
    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (rdy_in && clear_flag),
        .alloc    (alloc_oh & {DEPTH{disp_fire}}),
        .free     (issue_oh),
        .eligible (ent_elig),
        .oldest   (oldest_oh),
        .any      (any_elig)
    );

    // oldest_oh is one-hot, so an OR-reduction is a clean mux
    always_comb begin
        sel_pl = '0;
        for (int i = 0; i < DEPTH; i++)
            if (oldest_oh[i]) sel_pl = sel_pl | ent_q[i].pl;
    end

    // Issue register: payload only moves on a load with something selected,
    // so a held or dropped op keeps its fields stable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            iss_valid  <= 1'b0;
            iss_op     <= '0;
            iss_vj     <= '0;
            iss_vk     <= '0;
            iss_imm    <= '0;
            iss_pc     <= '0;
            iss_itype  <= 1'b0;
            iss_rob_id <= '0;
        end else if (rdy_in) begin
            if (clear_flag) begin
                iss_valid <= 1'b0;
            end else if (iss_load) begin
                iss_valid <= any_elig;
                if (any_elig) begin
                    iss_op     <= sel_pl.op;
                    iss_vj     <= sel_pl.vj;
                    iss_vk     <= sel_pl.vk;
                    iss_imm    <= sel_pl.imm;
                    iss_pc     <= sel_pl.pc;
                    iss_itype  <= sel_pl.itype;
                    iss_rob_id <= sel_pl.rob_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_rs_issue_queue
//   Directed scenarios followed by random traffic, all compared each cycle
//   against an age-ordered queue model of the reservation station.
// ---------------------------------------------------------------------------
module tb_rs_issue_queue;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag;
    logic        in_valid, in_ready;
    logic [6:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc;
    logic        in_qj_busy, in_qk_busy, in_itype;
    logic [4:0]  in_qj, in_qk, in_rob_id;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_rob_id;
    logic [63:0] cdb_val;
    logic        iss_valid, iss_ready, iss_itype;
    logic [6:0]  iss_op;
    logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
    logic [4:0]  iss_rob_id;
    logic [3:0]  count;

    always #5 clk_in = ~clk_in;

    rs_issue_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_vj(in_vj), .in_vk(in_vk), .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
        .in_qj(in_qj), .in_qk(in_qk), .in_imm(in_imm), .in_pc(in_pc),
        .in_itype(in_itype), .in_rob_id(in_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_itype(iss_itype), .iss_rob_id(iss_rob_id), .count(count)
    );

    // Reference model: ops kept in dispatch order, oldest first
    typedef struct {
        logic [6:0]  op;
        logic [31:0] vj, vk, imm, pc;
        bit          jb, kb;
        logic [4:0]  qj, qk, rob;
        bit          itype;
    } mop_t;

    mop_t mq[$];
    mop_t m_iss;
    bit   m_iss_v;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void snoop(input logic [4:0] tag, output bit hit, output logic [31:0] v);
        hit = 0;
        v   = '0;
        for (int k = 0; k < 2; k++)
            if (!hit && cdb_valid[k] && cdb_rob_id[k*5 +: 5] == tag) begin
                hit = 1;
                v   = cdb_val[k*32 +: 32];
            end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iss   = '{default: 0};
        m_iss_v = 0;
    endtask

    task automatic model_edge();
        int          idx, n0;
        bit          h;
        logic [31:0] v;
        mop_t        n;
        if (!rdy_in) return;
        if (clear_flag) begin
            mq.delete();
            m_iss_v = 0;
            return;
        end
        n0 = mq.size();
        if (!m_iss_v || iss_ready) begin
            idx = -1;
            for (int i = 0; i < mq.size(); i++)
                if (idx < 0 && !mq[i].jb && !mq[i].kb) idx = i;
            if (idx >= 0) begin
                m_iss   = mq[idx];
                m_iss_v = 1;
                mq.delete(idx);
            end else begin
                m_iss_v = 0;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].jb) begin
                snoop(mq[i].qj, h, v);
                if (h) begin mq[i].jb = 0; mq[i].vj = v; end
            end
            if (mq[i].kb) begin
                snoop(mq[i].qk, h, v);
                if (h) begin mq[i].kb = 0; mq[i].vk = v; end
            end
        end
        if (in_valid && n0 < DEPTH) begin
            n.op = in_op; n.vj = in_vj; n.vk = in_vk; n.imm = in_imm; n.pc = in_pc;
            n.jb = in_qj_busy; n.kb = in_qk_busy; n.qj = in_qj; n.qk = in_qk;
            n.rob = in_rob_id; n.itype = in_itype;
            if (n.jb) begin snoop(in_qj, h, v); if (h) begin n.jb = 0; n.vj = v; end end
            if (n.kb) begin snoop(in_qk, h, v); if (h) begin n.kb = 0; n.vk = v; end end
            mq.push_back(n);
        end
    endtask

    // One clock: check combinational status, advance model, check issue port
    task automatic step();
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        model_edge();
        @(posedge clk_in);
        #1;
        chk("iss_valid", 64'(iss_valid), 64'(m_iss_v));
        chk("iss_rob_id", 64'(iss_rob_id), 64'(m_iss.rob));
        chk("iss_op", 64'(iss_op), 64'(m_iss.op));
        chk("iss_vj", 64'(iss_vj), 64'(m_iss.vj));
        chk("iss_vk", 64'(iss_vk), 64'(m_iss.vk));
        chk("iss_imm", 64'(iss_imm), 64'(m_iss.imm));
        chk("iss_pc", 64'(iss_pc), 64'(m_iss.pc));
        chk("iss_itype", 64'(iss_itype), 64'(m_iss.itype));
    endtask

    task automatic idle();
        rdy_in = 1; clear_flag = 0; in_valid = 0; cdb_valid = '0;
    endtask

    task automatic disp(input logic [4:0] rob, input logic jb, input logic [4:0] qj,
                        input logic kb, input logic [4:0] qk,
                        input logic [31:0] vj, input logic [31:0] vk);
        idle();
        in_valid = 1; in_op = 7'h33; in_rob_id = rob;
        in_qj_busy = jb; in_qj = qj; in_qk_busy = kb; in_qk = qk;
        in_vj = vj; in_vk = vk; in_itype = rob[0];
        in_imm = 32'h100 + 32'(rob);
        in_pc  = 32'h8000_0000 + (32'(rob) << 2);
    endtask

    initial begin
        rst_in = 0; iss_ready = 1; idle();
        in_op = '0; in_vj = '0; in_vk = '0; in_imm = '0; in_pc = '0; in_itype = 0;
        in_qj_busy = 0; in_qk_busy = 0; in_qj = '0; in_qk = '0; in_rob_id = '0;
        cdb_rob_id = '0; cdb_val = '0;
        model_reset();

        // Reset state
        #2 rst_in = 1;
        #2;
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_iss_vj", 64'(iss_vj), 64'd0);
        @(posedge clk_in); #1;
        rst_in = 0;

        // Age order: A,B,C wait on tag 20, wake together, D lands in slot 0
        iss_ready = 0;
        disp(5'd3, 1, 5'd20, 0, 5'd0, 32'h0, 32'hA); step();
        disp(5'd7, 1, 5'd20, 0, 5'd0, 32'h0, 32'hB); step();
        disp(5'd1, 1, 5'd20, 0, 5'd0, 32'h0, 32'hC); step();
        idle(); cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd20}; cdb_val = {32'h0, 32'h55}; step();
        chk("age_not_yet", 64'(iss_valid), 64'd0);
        idle(); step();
        chk("age_A", 64'(iss_rob_id), 64'd3);
        chk("age_A_vj", 64'(iss_vj), 64'h55);
        disp(5'd2, 0, 5'd0, 0, 5'd0, 32'hD, 32'hD); step();
        idle(); iss_ready = 1;
        step(); chk("age_B", 64'(iss_rob_id), 64'd7);
        step(); chk("age_C", 64'(iss_rob_id), 64'd1);
        step(); chk("age_D", 64'(iss_rob_id), 64'd2);
        step(); chk("age_empty", 64'(iss_valid), 64'd0);

        // Dual-CDB wakeup
        disp(5'd12, 1, 5'd4, 1, 5'd9, 32'h0, 32'h0); step();
        idle(); cdb_valid = 2'b11; cdb_rob_id = {5'd9, 5'd4}; cdb_val = {32'h22, 32'h11}; step();
        chk("dual_wait", 64'(iss_valid), 64'd0);
        idle(); step();
        chk("dual_valid", 64'(iss_valid), 64'd1);
        chk("dual_vj", 64'(iss_vj), 64'h11);
        chk("dual_vk", 64'(iss_vk), 64'h22);

        // Dispatch bypass from channel 1
        disp(5'd13, 1, 5'd5, 0, 5'd0, 32'h0, 32'h77);
        cdb_valid = 2'b10; cdb_rob_id = {5'd5, 5'd0}; cdb_val = {32'hDEAD, 32'h0}; step();
        idle(); step();
        chk("byp_valid", 64'(iss_valid), 64'd1);
        chk("byp_vj", 64'(iss_vj), 64'hDEAD);
        chk("byp_rob", 64'(iss_rob_id), 64'd13);

        // Both channels carry the same tag: channel 0 wins
        disp(5'd14, 0, 5'd0, 1, 5'd6, 32'h1, 32'h0);
        cdb_valid = 2'b11; cdb_rob_id = {5'd6, 5'd6}; cdb_val = {32'hBBBB, 32'hAAAA}; step();
        idle(); step();
        chk("lowch_vk", 64'(iss_vk), 64'hAAAA);
        step();

        // Back-pressure and full
        iss_ready = 0;
        for (int i = 0; i < 9; i++) begin
            disp(5'(10 + i), 0, 5'd0, 0, 5'd0, 32'(i), 32'(i * 2));
            step();
            chk("bp_count", 64'(count), 64'((i == 0) ? 1 : i));
            if (i > 0) chk("bp_hold", 64'(iss_rob_id), 64'd10);
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        disp(5'd19, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0); step();
        chk("full_ignored", 64'(count), 64'd8);
        chk("full_hold", 64'(iss_rob_id), 64'd10);
        idle(); iss_ready = 1;
        for (int j = 1; j < 9; j++) begin
            step();
            chk("drain_order", 64'(iss_rob_id), 64'(10 + j));
        end
        step();
        chk("drain_done", 64'(iss_valid), 64'd0);

        // Flush with 5 entries plus a held issue
        iss_ready = 0;
        for (int i = 0; i < 6; i++) begin
            disp(5'(20 + i), 0, 5'd0, 0, 5'd0, 32'h0, 32'h0); step();
        end
        chk("pre_flush_count", 64'(count), 64'd5);
        disp(5'd26, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0); clear_flag = 1; step();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(iss_valid), 64'd0);
        idle(); step();
        chk("flush_dropped", 64'(count), 64'd0);

        // Stall: nothing moves, broadcast lost
        iss_ready = 1;
        disp(5'd29, 1, 5'd3, 0, 5'd0, 32'h0, 32'h0); step();
        disp(5'd28, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0);
        rdy_in = 0; clear_flag = 1;
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd3}; cdb_val = {32'h0, 32'h99}; step();
        chk("stall_count", 64'(count), 64'd1);
        idle(); step(); step();
        chk("stall_lost", 64'(iss_valid), 64'd0);
        idle(); cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd3}; cdb_val = {32'h0, 32'h99}; step();
        idle(); step();
        chk("stall_rewake", 64'(iss_rob_id), 64'd29);
        chk("stall_rewake_vj", 64'(iss_vj), 64'h99);
        step();

        // Reset asserted between edges with a dispatch pending
        iss_ready = 0;
        disp(5'd21, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0); step();
        disp(5'd22, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0); step();
        disp(5'd23, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0);
        #3 rst_in = 1;
        #1;
        chk("amid_valid", 64'(iss_valid), 64'd0);
        chk("amid_count", 64'(count), 64'd0);
        chk("amid_rob", 64'(iss_rob_id), 64'd0);
        in_valid = 0;
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 0;
        idle(); iss_ready = 1; step();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            rdy_in     = ($urandom_range(0, 15) != 0);
            clear_flag = ($urandom_range(0, 63) == 0);
            iss_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_op      = 7'($urandom);
            in_vj      = $urandom;
            in_vk      = $urandom;
            in_imm     = $urandom;
            in_pc      = $urandom;
            in_itype   = 1'($urandom);
            in_rob_id  = 5'($urandom);
            in_qj_busy = 1'($urandom);
            in_qk_busy = 1'($urandom);
            in_qj      = 5'($urandom_range(0, 7));
            in_qk      = 5'($urandom_range(0, 7));
            cdb_valid  = 2'($urandom);
            cdb_rob_id = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cdb_val    = {$urandom, $urandom};
            step();
        end

        idle();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
